// File: rtl/fortaegis_capture_ctrl.sv
// Capture sequencer for the Fortaegis histogram/top-3 datapath: windows Collect, waits for SortValid,
// holds the top-3 result for the host. Optional WAIT watchdog under FORTAEGIS_CAPTURE_TIMEOUT_EN.
module fortaegis_capture_ctrl #(
    parameter int DATA_SIZE   = 4,
    parameter int LENGTH_SIZE = 6,
    parameter int WIN_SIZE    = 16,
    parameter int GAP_CYC     = 20,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic                   Continuous,
    input  logic [WIN_SIZE-1:0]    WinLen,
    output logic                   Collect,
    input  logic                   SortValid,
    input  logic [DATA_SIZE-1:0]   InData1,
    input  logic [DATA_SIZE-1:0]   InData2,
    input  logic [DATA_SIZE-1:0]   InData3,
    input  logic [LENGTH_SIZE-1:0] InCount1,
    input  logic [LENGTH_SIZE-1:0] InCount2,
    input  logic [LENGTH_SIZE-1:0] InCount3,
    output logic                   ResValid,
    input  logic                   ResReady,
    output logic [DATA_SIZE-1:0]   ResData1,
    output logic [DATA_SIZE-1:0]   ResData2,
    output logic [DATA_SIZE-1:0]   ResData3,
    output logic [LENGTH_SIZE-1:0] ResCount1,
    output logic [LENGTH_SIZE-1:0] ResCount2,
    output logic [LENGTH_SIZE-1:0] ResCount3,
    output logic                   Busy,
    output logic                   Overrun,
    output logic                   Timeout,
    output logic [1:0]             dbg_state
);

    // Handshake: a result moves to the host on every cycle where ResValid and ResReady are both 1.
    // ResValid never drops without a transfer, and Res* never change while ResValid=1 unless a
    // transfer happens in that same cycle.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WAIT    = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    localparam logic [WIN_SIZE-1:0] MIN_WL   = WIN_SIZE'(4);
    localparam logic [WIN_SIZE-1:0] GAP_LOAD = WIN_SIZE'(GAP_CYC);
    localparam logic [WIN_SIZE-1:0] ONE      = WIN_SIZE'(1);

    state_t              state;
    state_t              state_nx;
    logic [WIN_SIZE-1:0] cnt;
    logic [WIN_SIZE-1:0] cnt_nx;
    logic                capture;
    logic                clr_sticky;
    logic                wait_expired;
    logic                load_res;
    logic                drop_res;

`ifdef FORTAEGIS_CAPTURE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    function automatic logic [WIN_SIZE-1:0] clamp_wl(input logic [WIN_SIZE-1:0] w);
        return (w < MIN_WL) ? MIN_WL : w;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Collect <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            Collect <= (state_nx == S_COLLECT);
            Busy    <= (state_nx != S_IDLE);
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        capture      = 1'b0;
        clr_sticky   = 1'b0;
        wait_expired = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nx   = S_COLLECT;
                    cnt_nx     = clamp_wl(WinLen);
                    clr_sticky = 1'b1;
                end
            end
            S_COLLECT: begin
                if (cnt == ONE) state_nx = S_WAIT;
                else            cnt_nx   = cnt - ONE;
            end
            S_WAIT: begin
                if (SortValid) begin
                    capture  = 1'b1;
                    state_nx = S_GAP;
                    cnt_nx   = GAP_LOAD;
                end
`ifdef FORTAEGIS_CAPTURE_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    wait_expired = 1'b1;
                    state_nx     = S_IDLE;
                end
`endif
            end
            S_GAP: begin
                if (cnt == ONE) begin
                    if (Continuous) begin
                        state_nx = S_COLLECT;
                        cnt_nx   = clamp_wl(WinLen);
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides everything the state logic decided this cycle.
        if (Abort) begin
            state_nx     = S_IDLE;
            cnt_nx       = '0;
            capture      = 1'b0;
            clr_sticky   = 1'b0;
            wait_expired = 1'b0;
        end
    end

    assign load_res  = capture && (!ResValid || ResReady);
    assign drop_res  = capture && ResValid && !ResReady;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ResValid  <= 1'b0;
            ResData1  <= '0;
            ResData2  <= '0;
            ResData3  <= '0;
            ResCount1 <= '0;
            ResCount2 <= '0;
            ResCount3 <= '0;
        end else if (load_res) begin
            ResValid  <= 1'b1;
            ResData1  <= InData1;
            ResData2  <= InData2;
            ResData3  <= InData3;
            ResCount1 <= InCount1;
            ResCount2 <= InCount2;
            ResCount3 <= InCount3;
        end else if (ResValid && ResReady) begin
            ResValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             Overrun <= 1'b0;
        else if (clr_sticky) Overrun <= 1'b0;
        else if (drop_res)   Overrun <= 1'b1;
    end

`ifdef FORTAEGIS_CAPTURE_TIMEOUT_EN
    // Counts consecutive WAIT cycles; zero on the first cycle of each WAIT visit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            Timeout  <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT && state_nx == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (clr_sticky)        Timeout <= 1'b0;
            else if (wait_expired) Timeout <= 1'b1;
        end
    end
`else
    // No watchdog in this build: the flag is constant 0 for any legal TIMEOUT.
    assign Timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_fortaegis_capture_ctrl.sv
// Directed bench for fortaegis_capture_ctrl; covers the watchdog when FORTAEGIS_CAPTURE_TIMEOUT_EN is defined.
module tb_fortaegis_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Start = 1'b0, Abort = 1'b0, Continuous = 1'b0;
    logic [15:0] WinLen = '0;
    logic       Collect, SortValid = 1'b0;
    logic [3:0] InData1 = '0, InData2 = '0, InData3 = '0;
    logic [5:0] InCount1 = '0, InCount2 = '0, InCount3 = '0;
    logic       ResValid, ResReady = 1'b0;
    logic [3:0] ResData1, ResData2, ResData3;
    logic [5:0] ResCount1, ResCount2, ResCount3;
    logic       Busy, Overrun, Timeout;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [29:0] exp_q[$];

    fortaegis_capture_ctrl dut (
        .clk(clk), .rst(rst), .Start(Start), .Abort(Abort), .Continuous(Continuous),
        .WinLen(WinLen), .Collect(Collect), .SortValid(SortValid),
        .InData1(InData1), .InData2(InData2), .InData3(InData3),
        .InCount1(InCount1), .InCount2(InCount2), .InCount3(InCount3),
        .ResValid(ResValid), .ResReady(ResReady),
        .ResData1(ResData1), .ResData2(ResData2), .ResData3(ResData3),
        .ResCount1(ResCount1), .ResCount2(ResCount2), .ResCount3(ResCount3),
        .Busy(Busy), .Overrun(Overrun), .Timeout(Timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] pack(input logic [3:0] d1, input logic [5:0] c1,
                                         input logic [3:0] d2, input logic [5:0] c2,
                                         input logic [3:0] d3, input logic [5:0] c3);
        return {d1, c1, d2, c2, d3, c3};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] wl);
        WinLen = wl;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
    endtask

    task automatic count_collect(output int n);
        n = 0;
        while (Collect && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 600) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_sort(input logic [29:0] v);
        {InData1, InCount1, InData2, InCount2, InData3, InCount3} = v;
        SortValid = 1'b1;
        tick();
        SortValid = 1'b0;
    endtask

    task automatic do_abort();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
    endtask

    task automatic accept(input string tag);
        check({tag, "_valid"}, ResValid, 1);
        if (exp_q.size() == 0) check({tag, "_q_empty"}, 1, 0);
        else check(tag, pack(ResData1, ResCount1, ResData2, ResCount2, ResData3, ResCount3),
                   exp_q.pop_front());
        ResReady = 1'b1;
        tick();
        ResReady = 1'b0;
    endtask

    initial begin
        logic [29:0] va, vb, vc, vd;
        int n;
        va = pack(4'd5, 6'd40, 4'd2, 6'd12, 4'd9, 6'd7);
        vb = pack(4'd1, 6'd33, 4'd7, 6'd20, 4'd3, 6'd2);
        vc = pack(4'd11, 6'd60, 4'd4, 6'd31, 4'd0, 6'd1);
        vd = pack(4'd15, 6'd63, 4'd14, 6'd62, 4'd13, 6'd61);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_collect", Collect, 0);
        check("rst_resvalid", ResValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_overrun", Overrun, 0);
        check("rst_timeout", Timeout, 0);
        check("rst_res", pack(ResData1, ResCount1, ResData2, ResCount2, ResData3, ResCount3), 0);
        check("rst_state", dbg_state, 0);

        // SortValid while idle must not capture.
        pulse_sort(vd);
        check("idle_sort_ignored", ResValid, 0);

        // Basic single capture with WinLen=10.
        do_start(16'd10);
        check("t1_collect_rise", Collect, 1);
        count_collect(n);
        check("t1_win_len", n, 10);
        check("t1_wait_state", dbg_state, 2);
        check("t1_busy_wait", Busy, 1);
        pulse_sort(va);
        exp_q.push_back(va);
        check("t1_resvalid", ResValid, 1);
        check("t1_data1", ResData1, 5);
        check("t1_count1", ResCount1, 40);
        check("t1_data3", ResData3, 9);
        check("t1_count3", ResCount3, 7);
        accept("t1_result");
        check("t1_resvalid_clr", ResValid, 0);
        wait_idle(n);
        check("t1_gap_len", n + 1, 20);
        check("t1_collect_idle", Collect, 0);

        // Short window clamps to four cycles; Abort from WAIT.
        do_start(16'd0);
        count_collect(n);
        check("t2_win_min", n, 4);
        do_start(16'd2);
        check("t2_start_busy_ignored", dbg_state, 2);
        do_abort();
        check("t2_abort_wait_busy", Busy, 0);

        // Abort during COLLECT, then a late SortValid, then Start+Abort together.
        do_start(16'd10);
        repeat (3) tick();
        do_abort();
        check("t4_abort_collect", Collect, 0);
        check("t4_abort_state", dbg_state, 0);
        pulse_sort(vd);
        check("t4_sort_ignored", ResValid, 0);
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        check("t4_start_abort_busy", Busy, 0);
        check("t4_start_abort_collect", Collect, 0);

        // Capture coinciding with a transfer replaces the held result without Overrun.
        do_start(16'd5);
        count_collect(n);
        check("t5_win", n, 5);
        pulse_sort(va);
        exp_q.push_back(va);
        wait_idle(n);
        do_start(16'd5);
        count_collect(n);
        check("t5_held_valid", ResValid, 1);
        check("t5_held", pack(ResData1, ResCount1, ResData2, ResCount2, ResData3, ResCount3),
              exp_q.pop_front());
        ResReady = 1'b1;
        pulse_sort(vb);
        ResReady = 1'b0;
        exp_q.push_back(vb);
        check("t5_resvalid_kept", ResValid, 1);
        check("t5_overrun", Overrun, 0);
        accept("t5_new_result");
        wait_idle(n);

        // Continuous mode with the host stalled: second result is dropped.
        Continuous = 1'b1;
        do_start(16'd6);
        count_collect(n);
        check("t3_win1", n, 6);
        pulse_sort(vc);
        exp_q.push_back(vc);
        n = 1;
        while (!Collect && n < 200) begin
            n++;
            tick();
        end
        check("t3_gap_ge20", (n >= 20), 1);
        check("t3_rearmed", Collect, 1);
        count_collect(n);
        check("t3_win2", n, 6);
        pulse_sort(vd);
        check("t3_overrun", Overrun, 1);
        check("t3_first_kept", ResData1, 11);
        Continuous = 1'b0;
        wait_idle(n);
        check("t3_stop_idle", Busy, 0);
        check("t3_stop_collect", Collect, 0);
        accept("t3_result");
        check("t3_overrun_sticky", Overrun, 1);
        do_start(16'd8);
        check("t3_start_clears", Overrun, 0);
        do_abort();

`ifdef FORTAEGIS_CAPTURE_TIMEOUT_EN
        do_start(16'd4);
        count_collect(n);
        wait_idle(n);
        check("t6_timeout_cycles", n, 255);
        check("t6_timeout", Timeout, 1);
        check("t6_no_capture", ResValid, 0);
        do_start(16'd4);
        check("t6_start_clears", Timeout, 0);
        do_abort();
`else
        do_start(16'd4);
        count_collect(n);
        repeat (300) tick();
        check("t6_no_watchdog_busy", Busy, 1);
        check("t6_timeout_zero", Timeout, 0);
        do_abort();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
